// File: rtl/dff_clock_sequencer_pkg.sv
// rtl/dff_clock_sequencer_pkg.sv - shared constants and state encoding for the T/POR sequencer
package dff_clock_sequencer_pkg;

  // The DFF latch block uses the same pulse count; T-high must outlast it by one U cycle.
  localparam int DFF_PULSE_COUNT = 440;
  localparam int MIN_HIGH_DEF    = DFF_PULSE_COUNT + 1;

  typedef enum logic [1:0] {
    S_POR  = 2'd0,
    S_HALT = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/dff_clock_sequencer_phase_timer.sv
// rtl/dff_clock_sequencer_phase_timer.sv - loadable down-counter marking the last cycle of a phase
module dff_clock_sequencer_phase_timer #(
  parameter int W = 16
) (
  input  logic         U,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // RESET also loads, so load_val carries the power-on clear length in that cycle.
  always_ff @(posedge U) begin
    if (RESET || load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // High in the cycle whose closing edge takes the count to 0.
  assign zero = (count <= W'(1));

endmodule

// File: rtl/dff_clock_sequencer.sv
// rtl/dff_clock_sequencer.sv - emulated CPU clock T plus power-on clear/preset for the DFF array
module dff_clock_sequencer
  import dff_clock_sequencer_pkg::*;
#(
  parameter int HPW      = 16,
  parameter int PORW     = 8,
  parameter int CYCW     = 32,
  parameter int MIN_HIGH = MIN_HIGH_DEF
) (
  input  logic            U,
  input  logic            RESET,
  input  logic            run,
  input  logic            step_req,
  input  logic [HPW-1:0]  half_period,
  input  logic [PORW-1:0] por_len,
  output logic            T,
  output logic            _PC,
  output logic            _PS,
  output logic            busy,
  output logic            step_ack,
  output logic [CYCW-1:0] cycle_count
);

  localparam int TW = (HPW > PORW) ? HPW : PORW;
  localparam logic [TW-1:0] MIN_HIGH_T = TW'(MIN_HIGH);
  localparam logic [TW-1:0] ONE_T      = TW'(1);

  seq_state_t    state;
  logic          step_flag;
  logic          load;
  logic          zero;
  logic [TW-1:0] hp_ext;
  logic [TW-1:0] por_ext;
  logic [TW-1:0] high_len;
  logic [TW-1:0] low_len;
  logic [TW-1:0] load_val;

  // Phase lengths are captured by the timer load on phase entry only.
  always_comb begin
    hp_ext   = TW'(half_period);
    por_ext  = TW'(por_len);
    high_len = (hp_ext > MIN_HIGH_T) ? hp_ext : MIN_HIGH_T;
    low_len  = (hp_ext > ONE_T) ? hp_ext : ONE_T;
    load     = 1'b0;
    load_val = low_len;
    if (RESET) begin
      load_val = (por_ext > ONE_T) ? por_ext : ONE_T;
    end else begin
      case (state)
        S_HALT: if (run || step_req) begin
          load     = 1'b1;
          load_val = high_len;
        end
        S_HIGH: if (zero) begin
          load     = 1'b1;
          load_val = low_len;
        end
        S_LOW: if (zero && run && !step_flag) begin
          load     = 1'b1;
          load_val = high_len;
        end
        default: ;
      endcase
    end
  end

  dff_clock_sequencer_phase_timer #(.W(TW)) u_timer (
    .U        (U),
    .RESET    (RESET),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge U) begin
    if (RESET) begin
      state       <= S_POR;
      T           <= 1'b0;
      _PC         <= 1'b0;
      step_ack    <= 1'b0;
      step_flag   <= 1'b0;
      cycle_count <= '0;
    end else begin
      step_ack <= 1'b0;
      case (state)
        S_POR: if (zero) begin
          _PC   <= 1'b1;
          state <= S_HALT;
        end
        S_HALT: if (run || step_req) begin
          T           <= 1'b1;
          state       <= S_HIGH;
          cycle_count <= cycle_count + 1'b1;
          step_flag   <= !run;
        end
        S_HIGH: if (zero) begin
          T     <= 1'b0;
          state <= S_LOW;
        end
        S_LOW: if (zero) begin
          // A stepped cycle always halts, even if run rose meanwhile.
          if (run && !step_flag) begin
            T           <= 1'b1;
            state       <= S_HIGH;
            cycle_count <= cycle_count + 1'b1;
          end else begin
            state     <= S_HALT;
            step_ack  <= step_flag;
            step_flag <= 1'b0;
          end
        end
        default: state <= S_POR;
      endcase
    end
  end

  assign _PS  = 1'b1;
  assign busy = (state != S_HALT);

endmodule
